// File: rtl/data_sram_responder_pkg.sv
// Shared size encoding and byte-lane helper for the SRAM-like data port.
// Used by the responder and by requester-side lane logic.
package data_sram_responder_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   // Misaligned half/word accesses simply use the truncated offset.
   function automatic logic [3:0] byte_lanes(
      input logic [1:0] size,
      input logic [1:0] offset
   );
      logic [3:0] lanes;
      lanes = 4'b1111;
      case (size)
         SZ_BYTE: lanes = 4'b0001 << offset;
         SZ_HALF: lanes = offset[1] ? 4'b1100 : 4'b0011;
         default: lanes = 4'b1111;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/data_sram_responder_pipe.sv
// LATENCY-deep valid/data shift pipeline carrying completions in order.
// Stage 0 loads every cycle; the last stage is the completion output.
module dsram_resp_pipe #(
   parameter int LATENCY = 1,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic [LATENCY-1:0] vld;
   logic [DATA_W-1:0]  dat [LATENCY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
      end else begin
         vld[0] <= in_valid;
         dat[0] <= in_data;
         for (int i = 1; i < LATENCY; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
      end
   end

   assign out_valid = vld[LATENCY-1];
   assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: pipelined accept, byte-lane writes, in-order completions.
// Optional random backpressure via `define DSRAM_RESP_RAND_STALL_EN.
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int LATENCY     = 1,
   parameter int OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata
);

   localparam int CW = $clog2(OUTSTANDING + 1);

   logic [31:0]       mem [2**ADDR_W];
   logic [CW-1:0]     cnt;
   logic              base_ok;
   logic              accept;
   logic [ADDR_W-1:0] idx;
   logic [3:0]        lanes;
   logic [31:0]       rd_word;

   assign base_ok = !rst && (cnt < CW'(OUTSTANDING));

`ifdef DSRAM_RESP_RAND_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign data_addr_ok = base_ok && (lfsr[1:0] != 2'b00);
`else
   assign data_addr_ok = base_ok;
`endif

   assign accept  = data_req && data_addr_ok;
   assign idx     = data_addr[ADDR_W+1:2];
   assign lanes   = byte_lanes(data_size, data_addr[1:0]);
   assign rd_word = data_wr ? 32'h0 : mem[idx];

   // Array is deliberately not reset; accepted writes survive rst.
   always_ff @(posedge clk) begin
      if (accept && data_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (lanes[b]) mem[idx][8*b +: 8] <= data_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (accept && !data_data_ok) begin
         cnt <= cnt + CW'(1);
      end else if (!accept && data_data_ok) begin
         cnt <= cnt - CW'(1);
      end
   end

   dsram_resp_pipe #(
      .LATENCY (LATENCY),
      .DATA_W  (32)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept),
      .in_data   (rd_word),
      .out_valid (data_data_ok),
      .out_data  (data_rdata)
   );

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: table vectors on a default instance,
// streaming/backpressure and reset sequences, scoreboard on a LATENCY=3 instance.
module tb_data_sram_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // dut0: default parameters
   logic        rst0, req0, wr0, addr_ok0, data_ok0;
   logic [1:0]  size0;
   logic [31:0] addr0, wdata0, rdata0;

   // dut1: LATENCY=3, OUTSTANDING=2
   logic        rst1, req1, wr1, addr_ok1, data_ok1;
   logic [1:0]  size1;
   logic [31:0] addr1, wdata1, rdata1;

   data_sram_responder dut0 (
      .clk          (clk),
      .rst          (rst0),
      .data_req     (req0),
      .data_wr      (wr0),
      .data_size    (size0),
      .data_addr    (addr0),
      .data_wdata   (wdata0),
      .data_addr_ok (addr_ok0),
      .data_data_ok (data_ok0),
      .data_rdata   (rdata0)
   );

   data_sram_responder #(
      .LATENCY     (3),
      .OUTSTANDING (2)
   ) dut1 (
      .clk          (clk),
      .rst          (rst1),
      .data_req     (req1),
      .data_wr      (wr1),
      .data_size    (size1),
      .data_addr    (addr1),
      .data_wdata   (wdata1),
      .data_addr_ok (addr_ok1),
      .data_data_ok (data_ok1),
      .data_rdata   (rdata1)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [1:0] sz,
                                         input logic [1:0] off);
      logic [31:0] m;
      case (sz)
         2'd0:    m = 32'hFF << (8 * off);
         2'd1:    m = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
         default: m = 32'hFFFF_FFFF;
      endcase
      return (old & ~m) | (wd & m);
   endfunction

   // Scoreboards: expected completions queued at the negedge before acceptance.
   logic [31:0] q0[$], q1[$];
   logic [31:0] m0[int], m1[int];
   int          out1 = 0;
   bit          sb0_on = 1'b0;

   always @(negedge clk) begin
      logic [31:0] e;
      int          k;
      if (rst1) begin
         q1.delete();
         out1 = 0;
      end else begin
         if (data_ok1) begin
            if (q1.size() == 0) chk("sb1_spurious", 32'd1, 32'd0);
            else begin
               e = q1.pop_front();
               chk("sb1_rdata", rdata1, e);
            end
         end
         if (req1 && addr_ok1) begin
            k = int'(addr1[13:2]);
            if (wr1) begin
               q1.push_back(32'h0);
               m1[k] = merge(m1.exists(k) ? m1[k] : 32'h0, wdata1,
                             size1, addr1[1:0]);
            end else begin
               q1.push_back(m1[k]);
            end
         end
         out1 = out1 + ((req1 && addr_ok1) ? 1 : 0) - (data_ok1 ? 1 : 0);
         if (out1 > 2 || out1 < 0) chk("sb1_outstanding", out1, 32'd2);
      end
   end

   always @(negedge clk) begin
      logic [31:0] e;
      int          k;
      if (sb0_on && !rst0) begin
         if (data_ok0) begin
            if (q0.size() == 0) chk("sb0_spurious", 32'd1, 32'd0);
            else begin
               e = q0.pop_front();
               chk("sb0_rdata", rdata0, e);
            end
         end
         if (req0 && addr_ok0) begin
            k = int'(addr0[13:2]);
            if (wr0) begin
               q0.push_back(32'h0);
               m0[k] = merge(m0.exists(k) ? m0[k] : 32'h0, wdata0,
                             size0, addr0[1:0]);
            end else begin
               q0.push_back(m0[k]);
            end
         end
      end
   end

   // Single transaction on dut0; starts just after a posedge.
   task automatic txn0(input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic got);
      req0 = 1'b1; wr0 = wr; size0 = sz; addr0 = a; wdata0 = wd;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (addr_ok0) break;
      end
      @(posedge clk); #1;
      req0 = 1'b0;
      @(negedge clk);
      got = data_ok0;
      rd  = rdata0;
      @(posedge clk); #1;
   endtask

   // Stream n word requests to dut1 with req held high.
   task automatic stream1(input logic wr, input int n, input bit pat);
      int idx = 0;
      int cyc = 0;
      while (idx < n && cyc < 200) begin
         req1 = 1'b1; wr1 = wr; size1 = 2'd2;
         addr1 = 32'h40 + 32'(idx * 4);
         wdata1 = 32'hC0DE_0000 + 32'(idx);
         @(negedge clk);
`ifndef DSRAM_RESP_RAND_STALL_EN
         if (pat && cyc < 8)
            chk($sformatf("bp_addr_ok[%0d]", cyc), 32'(addr_ok1),
                32'((cyc % 4) < 2));
`endif
         if (addr_ok1) idx++;
         cyc++;
         @(posedge clk); #1;
      end
      req1 = 1'b0;
      chk("bp_all_accepted", 32'(idx), 32'(n));
      repeat (8) @(posedge clk);
      #1;
   endtask

   vec_t        v[15];
   logic [31:0] rd;
   logic        got;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      v[0]  = '{1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF, 32'h0};
      v[1]  = '{1'b0, 2'd2, 32'h100, 32'h0,         32'hDEAD_BEEF};
      v[2]  = '{1'b1, 2'd2, 32'h200, 32'h0,         32'h0};
      v[3]  = '{1'b1, 2'd0, 32'h201, 32'h0000_AB00, 32'h0};
      v[4]  = '{1'b1, 2'd1, 32'h202, 32'h1234_0000, 32'h0};
      v[5]  = '{1'b0, 2'd2, 32'h200, 32'h0,         32'h1234_AB00};
      v[6]  = '{1'b1, 2'd0, 32'h203, 32'hEF00_0000, 32'h0};
      v[7]  = '{1'b1, 2'd1, 32'h201, 32'h0000_BEEF, 32'h0};
      v[8]  = '{1'b0, 2'd2, 32'h200, 32'h0,         32'hEF34_BEEF};
      v[9]  = '{1'b1, 2'd3, 32'h204, 32'h1122_3344, 32'h0};
      v[10] = '{1'b0, 2'd2, 32'h204, 32'h0,         32'h1122_3344};
      v[11] = '{1'b1, 2'd0, 32'h204, 32'h0000_00AA, 32'h0};
      v[12] = '{1'b0, 2'd2, 32'h204, 32'h0,         32'h1122_33AA};
      v[13] = '{1'b1, 2'd2, 32'h300, 32'h55AA_55AA, 32'h0};
      v[14] = '{1'b0, 2'd2, 32'h300, 32'h0,         32'h55AA_55AA};

      rst0 = 1'b1; req0 = 1'b0; wr0 = 1'b0; size0 = 2'd0;
      addr0 = '0; wdata0 = '0;
      rst1 = 1'b1; req1 = 1'b0; wr1 = 1'b0; size1 = 2'd0;
      addr1 = '0; wdata1 = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_addr_ok0", 32'(addr_ok0), 32'd0);
      chk("rst_data_ok0", 32'(data_ok0), 32'd0);
      chk("rst_rdata0",   rdata0,        32'h0);
      chk("rst_addr_ok1", 32'(addr_ok1), 32'd0);
      @(posedge clk); #1;
      rst0 = 1'b0; rst1 = 1'b0;
      @(negedge clk);
      chk("post_rst_addr_ok0", 32'(addr_ok0), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) begin
         txn0(v[i].wr, v[i].sz, v[i].addr, v[i].wd, rd, got);
         chk($sformatf("vec%0d_data_ok", i), 32'(got), 32'd1);
         chk($sformatf("vec%0d_rdata", i), rd, v[i].exp);
      end

`ifndef DSRAM_RESP_RAND_STALL_EN
      for (int i = 0; i < 8; i++) begin
         txn0(1'b1, 2'd2, 32'(i * 4), 32'hA500_0000 + 32'(i), rd, got);
      end
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            req0 = 1'b1; wr0 = 1'b0; size0 = 2'd2; addr0 = 32'(i * 4);
         end else begin
            req0 = 1'b0;
         end
         @(negedge clk);
         if (i < 8) chk($sformatf("b2b_addr_ok[%0d]", i), 32'(addr_ok0), 32'd1);
         if (i > 0) begin
            chk($sformatf("b2b_data_ok[%0d]", i - 1), 32'(data_ok0), 32'd1);
            chk($sformatf("b2b_rdata[%0d]", i - 1), rdata0,
                32'hA500_0000 + 32'(i - 1));
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("b2b_idle_data_ok", 32'(data_ok0), 32'd0);
      @(posedge clk); #1;
`endif

      stream1(1'b1, 6, 1'b0);
      stream1(1'b0, 6, 1'b1);
      chk("sb1_drained", 32'(q1.size()), 32'd0);

      // Reset between accept and completion of a read.
      req0 = 1'b1; wr0 = 1'b0; size0 = 2'd2; addr0 = 32'h300;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (addr_ok0) break;
      end
      @(posedge clk); #1;
      req0 = 1'b0;
      rst0 = 1'b1;
      @(negedge clk);
      chk("midrst_data_ok", 32'(data_ok0), 32'd0);
      chk("midrst_rdata",   rdata0,        32'h0);
      chk("midrst_addr_ok", 32'(addr_ok0), 32'd0);
      @(posedge clk); #1;
      rst0 = 1'b0;
      @(negedge clk);
      chk("after_rst_data_ok", 32'(data_ok0), 32'd0);
      chk("after_rst_addr_ok", 32'(addr_ok0), 32'd1);
      @(posedge clk); #1;
      txn0(1'b0, 2'd2, 32'h300, 32'h0, rd, got);
      chk("persist_data_ok", 32'(got), 32'd1);
      chk("persist_rdata",   rd,        32'h55AA_55AA);

`ifdef DSRAM_RESP_RAND_STALL_EN
      begin
         int idx = 0;
         int cyc = 0;
         int okc = 0;
         bit acc;
         sb0_on = 1'b1;
         req0 = 1'b1; wr0 = 1'b1; size0 = 2'd2;
         addr0 = 32'h400; wdata0 = $urandom;
         while (idx < 1000 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            acc = addr_ok0;
            if (addr_ok0) okc++;
            @(posedge clk); #1;
            if (acc) begin
               idx++;
               if (idx < 16) begin
                  wr0 = 1'b1; size0 = 2'd2;
                  addr0 = 32'h400 + 32'(idx * 4);
               end else begin
                  wr0   = 1'($urandom_range(0, 1));
                  size0 = 2'($urandom_range(0, 3));
                  addr0 = 32'h400 + 32'($urandom_range(0, 63));
               end
               wdata0 = $urandom;
            end
         end
         req0 = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         sb0_on = 1'b0;
         chk("rand_all_accepted", 32'(idx), 32'd1000);
         chk("rand_drained", 32'(q0.size()), 32'd0);
         tests++;
         if (okc * 100 < cyc * 70 || okc * 100 > cyc * 80) begin
            fails++;
            $display("FAIL rand_duty: got %0d/%0d expected 70-80%%", okc, cyc);
         end
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
